// File: rtl/packet_deframer_if.sv
// Link-side and message-side signals of the packet deframer, bundled so the
// deframer and its environment share one declaration of widths and directions.
interface packet_deframer_if #(
    parameter int PACKET_SIZE = 8,
    parameter int MESSAGE_BIT = 256,
    parameter int CHANNEL_BIT = 1
);
    // Link symbol stream
    logic                   in_valid;
    logic [PACKET_SIZE-1:0] in_data;
    logic                   in_ready;

    // Completed message hand-off
    logic                   msg_valid;
    logic                   msg_ready;
    logic [CHANNEL_BIT-1:0] msg_channel;
    logic [4:0]             msg_length;
    logic [MESSAGE_BIT-1:0] msg_data;

    // Status
    logic                   err_pulse;
    logic [2:0]             err_code;
    logic [15:0]            frame_count;

    // Environment side: drives symbols and consumes messages
    modport master (
        output in_valid, in_data, msg_ready,
        input  in_ready, msg_valid, msg_channel, msg_length, msg_data,
        input  err_pulse, err_code, frame_count
    );

    // Deframer side
    modport slave (
        input  in_valid, in_data, msg_ready,
        output in_ready, msg_valid, msg_channel, msg_length, msg_data,
        output err_pulse, err_code, frame_count
    );
endinterface

// File: rtl/packet_deframer.sv
// Packet deframer: walks header / channel / length / data / trailer symbols,
// packs data symbols LSB-first into a shadow payload and commits it to the
// message outputs when the trailer id matches the header id.
module packet_deframer #(
    parameter int PACKET_SIZE = 8,
    parameter int MESSAGE_BIT = 256,
    parameter int CHANNEL_BIT = 1,
    parameter int TIMEOUT     = 1023
) (
    input  logic             CLK,
    input  logic             RST,
    packet_deframer_if.slave bus
);

    localparam int         DATA_BITS = PACKET_SIZE - 1;
    localparam logic [2:0] TAG_HDR   = 3'b100;
    localparam logic [2:0] TAG_CHAN  = 3'b101;
    localparam logic [2:0] TAG_LEN   = 3'b110;
    localparam logic [2:0] TAG_TRL   = 3'b111;

    localparam logic [2:0] ERR_TAG     = 3'd1;
    localparam logic [2:0] ERR_ID      = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_PAD     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHAN,
        ST_LEN,
        ST_DATA,
        ST_END
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Frame shadow: filled while the frame is in flight
    logic [4:0]             r_id;
    logic [CHANNEL_BIT-1:0] r_chan;
    logic [4:0]             r_len;
    logic [MESSAGE_BIT-1:0] r_shadow;
    logic [8:0]             r_ptr;

    // Committed message and status
    logic                   r_msg_valid;
    logic [CHANNEL_BIT-1:0] r_msg_channel;
    logic [4:0]             r_msg_length;
    logic [MESSAGE_BIT-1:0] r_msg_data;
    logic                   r_err_pulse;
    logic [2:0]             r_err_code;
    logic [15:0]            r_frame_count;
    logic [15:0]            r_idle_cnt;

    // Symbol decode
    logic [PACKET_SIZE-1:0] w_in_data;
    logic [2:0]             w_tag;
    logic [4:0]             w_field5;
    logic                   w_is_data;
    logic                   w_is_hdr;
    logic                   w_is_chan;
    logic                   w_is_len;
    logic                   w_is_trl;
    logic                   w_chan_pad_nz;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_timeout;
    logic [8:0]             w_ptr_next;
    logic [8:0]             w_len_bits;
    logic [MESSAGE_BIT-1:0] w_data_shift;

    // FSM decisions
    logic       w_load_hdr;
    logic       w_load_chan;
    logic       w_load_len;
    logic       w_load_data;
    logic       w_commit;
    logic       w_unexpected;
    logic       w_err;
    logic [2:0] w_err_code;

    assign w_in_data = bus.in_data;
    assign w_tag     = w_in_data[PACKET_SIZE-1:PACKET_SIZE-3];
    assign w_field5  = w_in_data[4:0];
    assign w_is_data = !w_in_data[PACKET_SIZE-1];
    assign w_is_hdr  = (w_tag == TAG_HDR);
    assign w_is_chan = (w_tag == TAG_CHAN);
    assign w_is_len  = (w_tag == TAG_LEN);
    assign w_is_trl  = (w_tag == TAG_TRL);

    // Bits between the tag and the channel index must be zero
    assign w_chan_pad_nz = |(w_in_data[PACKET_SIZE-4:0] >> CHANNEL_BIT);

    // Only a trailer waiting on an unconsumed message is back-pressured
    assign w_in_ready = !((r_state == ST_END) && r_msg_valid && !bus.msg_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // Payload packing: bits shifted past MESSAGE_BIT fall off the top
    assign w_ptr_next   = r_ptr + 9'(DATA_BITS);
    assign w_len_bits   = {1'b0, r_len, 3'b000};
    assign w_data_shift = MESSAGE_BIT'(w_in_data[DATA_BITS-1:0]) << r_ptr;

    // This cycle is the TIMEOUT-th consecutive mid-frame cycle without a symbol
    assign w_timeout = (r_state != ST_IDLE) && !w_accept &&
                       (r_idle_cnt == 16'(TIMEOUT - 1));

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: registered state uses <= so every flop samples pre-edge values.
            r_state <= w_state_next;
        end
    end

    // Next-state, shadow load strobes and error selection
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_state_next = r_state;
        w_load_hdr   = 1'b0;
        w_load_chan  = 1'b0;
        w_load_len   = 1'b0;
        w_load_data  = 1'b0;
        w_commit     = 1'b0;
        w_unexpected = 1'b0;
        w_err        = 1'b0;
        w_err_code   = 3'd0;

        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_hdr) begin
                        w_load_hdr   = 1'b1;
                        w_state_next = ST_CHAN;
                    end
                end
                ST_CHAN: begin
                    if (!w_is_chan) begin
                        w_unexpected = 1'b1;
                    end else if (w_chan_pad_nz) begin
                        w_err        = 1'b1;
                        w_err_code   = ERR_PAD;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_load_chan  = 1'b1;
                        w_state_next = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (w_is_len) begin
                        w_load_len   = 1'b1;
                        w_state_next = ST_DATA;
                    end else begin
                        w_unexpected = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_is_data) begin
                        w_load_data = 1'b1;
                        if (w_ptr_next >= w_len_bits) begin
                            w_state_next = ST_END;
                        end
                    end else begin
                        w_unexpected = 1'b1;
                    end
                end
                ST_END: begin
                    if (w_is_trl) begin
                        w_state_next = ST_IDLE;
                        if (w_field5 == r_id) begin
                            w_commit = 1'b1;
                        end else begin
                            w_err      = 1'b1;
                            w_err_code = ERR_ID;
                        end
                    end else begin
                        w_unexpected = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase

            // A stray header both aborts the old frame and opens a new one
            if (w_unexpected) begin
                w_err      = 1'b1;
                w_err_code = ERR_TAG;
                if (w_is_hdr) begin
                    w_load_hdr   = 1'b1;
                    w_state_next = ST_CHAN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
        end else if (w_timeout) begin
            w_err        = 1'b1;
            w_err_code   = ERR_TIMEOUT;
            w_state_next = ST_IDLE;
        end
    end

    // Frame shadow capture
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_id     <= '0;
            r_chan   <= '0;
            r_len    <= '0;
            r_shadow <= '0;
            r_ptr    <= '0;
        end else begin
            if (w_load_hdr) begin
                r_id     <= w_field5;
                r_shadow <= '0;
                r_ptr    <= '0;
            end
            if (w_load_chan) begin
                r_chan <= w_in_data[CHANNEL_BIT-1:0];
            end
            if (w_load_len) begin
                r_len <= w_field5;
            end
            if (w_load_data) begin
                r_shadow <= r_shadow | w_data_shift;
                r_ptr    <= w_ptr_next;
            end
        end
    end

    // Message hand-off: a commit wins over a same-cycle consume
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_msg_valid   <= 1'b0;
            r_msg_channel <= '0;
            r_msg_length  <= '0;
            r_msg_data    <= '0;
            r_frame_count <= '0;
        end else if (w_commit) begin
            r_msg_valid   <= 1'b1;
            r_msg_channel <= r_chan;
            r_msg_length  <= r_len;
            r_msg_data    <= r_shadow;
            r_frame_count <= r_frame_count + 16'd1;
        end else if (r_msg_valid && bus.msg_ready) begin
            r_msg_valid <= 1'b0;
        end
    end

    // Error strobe; the code sticks until the next error
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err_pulse <= 1'b0;
            r_err_code  <= 3'd0;
        end else begin
            r_err_pulse <= w_err;
            if (w_err) begin
                r_err_code <= w_err_code;
            end
        end
    end

    // Mid-frame inactivity counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_idle_cnt <= '0;
        end else if ((r_state == ST_IDLE) || w_accept || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.msg_valid   = r_msg_valid;
    assign bus.msg_channel = r_msg_channel;
    assign bus.msg_length  = r_msg_length;
    assign bus.msg_data    = r_msg_data;
    assign bus.err_pulse   = r_err_pulse;
    assign bus.err_code    = r_err_code;
    assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_packet_deframer.sv
// Bench for packet_deframer: directed scenarios followed by randomized frames,
// all compared against a symbol-list reference model of the framing rules.
module tb_packet_deframer;

    localparam int PS = 8;
    localparam int MB = 256;
    localparam int CB = 1;
    localparam int TO = 4;

    localparam int P_IDLE = 0;
    localparam int P_CHAN = 1;
    localparam int P_LEN  = 2;
    localparam int P_DATA = 3;
    localparam int P_END  = 4;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    packet_deframer_if #(.PACKET_SIZE(PS), .MESSAGE_BIT(MB), .CHANNEL_BIT(CB)) bus ();

    packet_deframer #(
        .PACKET_SIZE(PS),
        .MESSAGE_BIT(MB),
        .CHANNEL_BIT(CB),
        .TIMEOUT    (TO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: frame progress plus the list of data symbols received
    int          m_phase;
    logic [4:0]  m_id;
    logic        m_ch;
    int          m_len;
    logic [6:0]  m_syms[$];
    int          m_idle;
    logic        m_mv;
    logic        m_mch;
    logic [4:0]  m_mlen;
    logic [MB-1:0] m_mdata;
    logic        m_errp;
    logic [2:0]  m_errc;
    logic [15:0] m_fc;

    task automatic check(input string tag, input logic [MB-1:0] got, input logic [MB-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_id    = '0;
        m_ch    = 1'b0;
        m_len   = 0;
        m_syms.delete();
        m_idle  = 0;
        m_mv    = 1'b0;
        m_mch   = 1'b0;
        m_mlen  = '0;
        m_mdata = '0;
        m_errp  = 1'b0;
        m_errc  = 3'd0;
        m_fc    = 16'd0;
    endtask

    task automatic raise(input logic [2:0] code);
        m_errp = 1'b1;
        m_errc = code;
    endtask

    task automatic start_frame(input logic [7:0] d);
        m_id = d[4:0];
        m_syms.delete();
        m_phase = P_CHAN;
    endtask

    task automatic unexpected(input logic [7:0] d);
        raise(3'd1);
        if (d[7:5] == 3'b100) start_frame(d);
        else m_phase = P_IDLE;
    endtask

    // Payload = concatenation of the 7-bit data fields, first symbol lowest
    function automatic logic [MB-1:0] packed_payload();
        logic [MB-1:0] p = '0;
        foreach (m_syms[i]) begin
            for (int b = 0; b < 7; b++) begin
                if (i * 7 + b < MB) p[i*7+b] = m_syms[i][b];
            end
        end
        return p;
    endfunction

    task automatic model_step(input bit acc, input logic [7:0] d, input bit mr);
        bit consume;
        bit commit;
        consume = m_mv && mr;
        commit  = 1'b0;
        m_errp  = 1'b0;
        if (acc) begin
            m_idle = 0;
            case (m_phase)
                P_IDLE: if (d[7:5] == 3'b100) start_frame(d);
                P_CHAN: begin
                    if (d[7:5] != 3'b101) unexpected(d);
                    else if (d[4:1] != 4'd0) begin
                        raise(3'd4);
                        m_phase = P_IDLE;
                    end else begin
                        m_ch    = d[0];
                        m_phase = P_LEN;
                    end
                end
                P_LEN: begin
                    if (d[7:5] == 3'b110) begin
                        m_len   = int'(d[4:0]);
                        m_phase = P_DATA;
                    end else unexpected(d);
                end
                P_DATA: begin
                    if (!d[7]) begin
                        m_syms.push_back(d[6:0]);
                        if (m_syms.size() * 7 >= m_len * 8) m_phase = P_END;
                    end else unexpected(d);
                end
                default: begin
                    if (d[7:5] == 3'b111) begin
                        if (d[4:0] == m_id) begin
                            commit  = 1'b1;
                            m_mch   = m_ch;
                            m_mlen  = 5'(m_len);
                            m_mdata = packed_payload();
                            m_fc    = m_fc + 16'd1;
                        end else raise(3'd2);
                        m_phase = P_IDLE;
                    end else unexpected(d);
                end
            endcase
        end else if (m_phase != P_IDLE) begin
            m_idle++;
            if (m_idle == TO) begin
                raise(3'd3);
                m_phase = P_IDLE;
                m_idle  = 0;
            end
        end else begin
            m_idle = 0;
        end
        if (commit) m_mv = 1'b1;
        else if (consume) m_mv = 1'b0;
    endtask

    task automatic check_outputs();
        check("msg_valid",   bus.msg_valid,   m_mv);
        check("msg_channel", bus.msg_channel, m_mch);
        check("msg_length",  bus.msg_length,  m_mlen);
        check("msg_data",    bus.msg_data,    m_mdata);
        check("err_pulse",   bus.err_pulse,   m_errp);
        check("err_code",    bus.err_code,    m_errc);
        check("frame_count", bus.frame_count, m_fc);
    endtask

    // One clock: drive at edge+1, check in_ready, then check registered outputs
    task automatic cycle(input bit v, input logic [7:0] d, input bit mr, output bit acc);
        bit exp_rdy;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.msg_ready = mr;
        #1;
        exp_rdy = !(m_phase == P_END && m_mv && !mr);
        check("in_ready", bus.in_ready, exp_rdy);
        acc = v && exp_rdy;
        model_step(acc, d, mr);
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input bit mr);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, mr, acc);
    endtask

    // Offer a symbol until accepted; msg_ready is either fixed or random per cycle
    task automatic send(input logic [7:0] d, input bit mr, input bit rand_mr);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 40) begin
            cycle(1'b1, d, rand_mr ? bit'($urandom_range(0, 1)) : mr, acc);
            tries++;
        end
        check("send_accepted", acc, 1'b1);
    endtask

    task automatic send_list(input logic [7:0] s[$], input bit mr);
        foreach (s[i]) send(s[i], mr, 1'b0);
    endtask

    // Async reset pulse; outputs are checked while RST is still high
    task automatic pulse_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.msg_ready = 1'b0;
        RST = 1'b1;
        #2;
        model_reset();
        check("rst_in_ready", bus.in_ready, 1'b1);
        check_outputs();
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_frame();
        logic [7:0] s[$];
        logic [4:0] id;
        int         ln;
        int         nd;
        int         r;
        id = 5'($urandom_range(0, 31));
        ln = $urandom_range(0, 31);
        nd = (ln == 0) ? 1 : (ln * 8 + 6) / 7;
        s.push_back(8'h80 | 8'(id));
        if ($urandom_range(0, 19) == 0) s.push_back(8'hA0 | 8'($urandom_range(0, 31)));
        else s.push_back(8'hA0 | 8'($urandom_range(0, 1)));
        s.push_back(8'hC0 | 8'(ln));
        for (int i = 0; i < nd; i++) s.push_back(8'($urandom_range(0, 127)));
        if ($urandom_range(0, 9) == 0) s.push_back(8'hE0 | 8'(id ^ 5'($urandom_range(1, 31))));
        else s.push_back(8'hE0 | 8'(id));
        if ($urandom_range(0, 9) == 0) s[$urandom_range(0, s.size() - 1)] = 8'($urandom_range(0, 255));
        foreach (s[i]) begin
            r = $urandom_range(0, 39);
            if (r == 0) idle($urandom_range(TO, TO + 1), bit'($urandom_range(0, 1)));
            else if (r < 8) idle($urandom_range(1, 2), bit'($urandom_range(0, 1)));
            send(s[i], 1'b0, 1'b1);
        end
    endtask

    initial begin
        logic [7:0] f33[$];
        logic [7:0] f34[$];
        logic [7:0] f36[$];
        bit         acc;

        f33 = '{8'h81, 8'hA1, 8'hC2, 8'h34, 8'h12, 8'h00, 8'hE1};
        f34 = '{8'h81, 8'hA1, 8'hC2, 8'h34, 8'h12, 8'h00, 8'hE2};
        f36 = '{8'h82, 8'hA0, 8'hC1, 8'h55, 8'h01};

        RST = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.msg_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check_outputs();
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Good frame with 7-bit packing
        send_list(f33, 1'b0);
        check("f33_valid", bus.msg_valid, 1'b1);
        check("f33_chan",  bus.msg_channel, 1'b1);
        check("f33_len",   bus.msg_length, 5'd2);
        check("f33_data",  bus.msg_data[15:0], 16'h0934);
        check("f33_count", bus.frame_count, 16'd1);
        idle(1, 1'b1);
        check("f33_taken", bus.msg_valid, 1'b0);

        // Trailer id mismatch from a clean reset
        pulse_reset();
        send_list(f34, 1'b0);
        check("f34_pulse", bus.err_pulse, 1'b1);
        check("f34_code",  bus.err_code, 3'd2);
        check("f34_valid", bus.msg_valid, 1'b0);
        check("f34_count", bus.frame_count, 16'd0);
        idle(1, 1'b0);
        check("f34_one_cycle", bus.err_pulse, 1'b0);

        // Header inside a frame restarts it; zero-length frame commits
        send_list('{8'h81, 8'hA0, 8'h83}, 1'b0);
        check("f35_pulse", bus.err_pulse, 1'b1);
        check("f35_code",  bus.err_code, 3'd1);
        send_list('{8'hA0, 8'hC0, 8'h05, 8'hE3}, 1'b0);
        check("f35_valid", bus.msg_valid, 1'b1);
        check("f35_len",   bus.msg_length, 5'd0);
        check("f35_chan",  bus.msg_channel, 1'b0);
        check("f35_data",  bus.msg_data[7:0], 8'h05);

        // Back-pressure on the trailer while the message is still held
        send_list(f36, 1'b0);
        cycle(1'b1, 8'hE2, 1'b0, acc);
        check("f36_stall0", bus.in_ready, 1'b0);
        cycle(1'b1, 8'hE2, 1'b0, acc);
        check("f36_stall1", acc, 1'b0);
        cycle(1'b1, 8'hE2, 1'b1, acc);
        check("f36_accept", acc, 1'b1);
        check("f36_valid",  bus.msg_valid, 1'b1);
        check("f36_data",   bus.msg_data[15:0], 16'h00D5);
        check("f36_len",    bus.msg_length, 5'd1);
        idle(1, 1'b1);

        // Mid-frame inactivity abort
        send(8'h81, 1'b0, 1'b0);
        idle(TO, 1'b0);
        check("to_pulse", bus.err_pulse, 1'b1);
        check("to_code",  bus.err_code, 3'd3);
        send(8'hA1, 1'b0, 1'b0);
        check("to_drop_pulse", bus.err_pulse, 1'b0);
        check("to_drop_code",  bus.err_code, 3'd3);

        // Reset mid-frame, then a normal frame
        send_list('{8'h81, 8'hA1, 8'hC2}, 1'b0);
        pulse_reset();
        check("rst_no_pulse", bus.err_pulse, 1'b0);
        send_list(f33, 1'b0);
        check("rst_recover_valid", bus.msg_valid, 1'b1);
        check("rst_recover_count", bus.frame_count, 16'd1);
        idle(1, 1'b1);

        // Randomized traffic
        for (int f = 0; f < 250; f++) begin
            rand_frame();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/packet_deframer.md
PACKET_DEFRAMER -- requirements
Module: packet_deframer

Interface
REQ-001 SHALL have parameter PACKET_SIZE, default 8, meaning link symbol width in bits (>=8).
REQ-002 SHALL have parameter MESSAGE_BIT, default 256, meaning payload register width in bits (>=248).
REQ-003 SHALL have parameter CHANNEL_BIT, default 1, meaning channel index width (1..5).
REQ-004 SHALL have parameter TIMEOUT, default 1023, meaning idle cycles allowed mid-frame before abort (1..65535).
REQ-005 SHALL have port CLK  in  1  clock, all state on rising edge.
REQ-006 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid  in  1  link symbol available.
REQ-008 SHALL have port in_data  in  PACKET_SIZE  link symbol.
REQ-009 SHALL have port in_ready  out  1  symbol accepted when in_valid && in_ready.
REQ-010 SHALL have port msg_valid  out  1  completed message held.
REQ-011 SHALL have port msg_ready  in  1  consumer takes message when msg_valid && msg_ready.
REQ-012 SHALL have port msg_channel  out  CHANNEL_BIT  channel of held message.
REQ-013 SHALL have port msg_length  out  5  payload length in bytes.
REQ-014 SHALL have port msg_data  out  MESSAGE_BIT  payload, byte 0 at bits [7:0].
REQ-015 SHALL have port err_pulse  out  1  one-cycle error strobe.
REQ-016 SHALL have port err_code  out  3  error cause, valid with err_pulse, else holds last value.
REQ-017 SHALL have port frame_count  out  16  committed frames, wraps 0xFFFF->0.

Function
REQ-018 SHALL decode tag = in_data[PACKET_SIZE-1:PACKET_SIZE-3]: 100 header(id=[4:0]), 101 channel(idx=[CHANNEL_BIT-1:0]), 110 length(len=[4:0]), 111 trailer(id=[4:0]); MSB=0 is data carrying [PACKET_SIZE-2:0].
REQ-019 SHALL use states IDLE, CHAN, LEN, DATA, END; one state step per accepted symbol only.
REQ-020 SHALL in IDLE on header: store id, clear data shadow and bit pointer to 0, go CHAN; all other symbols silently dropped.
REQ-021 SHALL in CHAN on channel tag: store idx, go LEN; if bits between tag and idx field are nonzero: err_code 4, go IDLE.
REQ-022 SHALL in LEN on length tag: store len, go DATA.
REQ-023 SHALL in DATA on data symbol: write PACKET_SIZE-1 bits at bit pointer (bits >= MESSAGE_BIT discarded), pointer += PACKET_SIZE-1 (9-bit); go END when new pointer >= len*8; len 0 still consumes exactly one data symbol.
REQ-024 SHALL in END on trailer with matching id: commit (msg_* <= shadow, msg_valid <= 1, frame_count += 1), go IDLE; id mismatch: err_code 2, no commit, go IDLE.
REQ-025 SHALL on any unexpected tag in CHAN/LEN/DATA/END: err_code 1, go IDLE; if that symbol is a header, restart as REQ-020 (go CHAN) in the same cycle.
REQ-026 SHALL drive in_ready = !(state==END && msg_valid && !msg_ready) combinationally; low only blocks trailer commit.
REQ-027 SHALL clear msg_valid on msg_valid && msg_ready unless a commit occurs the same cycle, in which case msg_valid stays 1 with new contents.
REQ-028 SHALL keep msg_channel/msg_length/msg_data stable while msg_valid && !msg_ready.
REQ-029 SHALL count cycles without accepted symbol while state != IDLE; at TIMEOUT: err_code 3, go IDLE; counter cleared on accepted symbol and in IDLE.
REQ-030 SHALL assert err_pulse for exactly one cycle per error; at most one error per cycle, priority 4 > 2 > 1 > 3.

Reset
REQ-031 SHALL on RST: state IDLE, msg_valid 0, msg_channel 0, msg_length 0, msg_data 0, err_pulse 0, err_code 0, frame_count 0, timeout counter 0, shadow registers 0; in_ready then 1.
REQ-032 SHALL on RST mid-frame discard partial frame with no err_pulse and no commit.

Verification
REQ-033 SHALL cover: 0x81,0xA1,0xC2,0x34,0x12,0x00,0xE1 -> msg_valid, channel 1, length 2, msg_data[15:0]=0x0934 (7-bit packing), frame_count 1.
REQ-034 SHALL cover: same frame with trailer 0xE2 -> err_pulse one cycle, err_code 2, msg_valid stays 0, frame_count 0.
REQ-035 SHALL cover: 0x81,0xA0,0x83 -> err_code 1 pulse, then 0xA0,0xC0,0x05,0xE3 commits channel 0, length 0, id 3.
REQ-036 SHALL cover: msg_ready held 0 with message pending, second frame to trailer -> in_ready 0 at trailer; msg_ready 1 -> trailer accepted same cycle, msg_valid stays 1 with second frame.
REQ-037 SHALL cover: TIMEOUT=4, header then 4 idle cycles -> err_code 3 pulse, state IDLE; 0xA1 next is dropped without error.
REQ-038 SHALL cover: RST asserted after 0xC2 mid-frame -> all outputs at REQ-031 values, no err_pulse, next full frame commits normally.
